// File: rtl/ceespu_pkg.sv
// ---------------------------------------------------------------------------
// ceespu_pkg
// Shared definitions for the ceespu pipeline.
//   ctr_e       : 2-bit saturating branch counter encodings
//                 (SNT=00, WNT=01, WT=10, ST=11)
//   INSTR_BYTES : instruction size in bytes; used for the fall-through PC
// ---------------------------------------------------------------------------
package ceespu_pkg;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/ceespu_branch_predictor_if.sv
// ---------------------------------------------------------------------------
// ceespu_branch_predictor_if
// Fetch/execute side bundle of the branch predictor.
//   lookup   : I_predictPC -> O_predictTaken, O_predictTarget
//   update   : I_updateValid, I_updatePC, I_updateTaken, I_updateTarget,
//              I_updatePredTaken, I_updatePredTarget
//   redirect : O_mispredict, O_redirectPC
// Modport master = pipeline (fetch/execute), slave = predictor.
// ---------------------------------------------------------------------------
interface ceespu_branch_predictor_if;

   logic [31:0] I_predictPC;
   logic        O_predictTaken;
   logic [31:0] O_predictTarget;

   logic        I_updateValid;
   logic [31:0] I_updatePC;
   logic        I_updateTaken;
   logic [31:0] I_updateTarget;
   logic        I_updatePredTaken;
   logic [31:0] I_updatePredTarget;

   logic        O_mispredict;
   logic [31:0] O_redirectPC;

   modport master (
      output I_predictPC,
      input  O_predictTaken, O_predictTarget,
      output I_updateValid, I_updatePC, I_updateTaken, I_updateTarget,
      output I_updatePredTaken, I_updatePredTarget,
      input  O_mispredict, O_redirectPC
   );

   modport slave (
      input  I_predictPC,
      output O_predictTaken, O_predictTarget,
      input  I_updateValid, I_updatePC, I_updateTaken, I_updateTarget,
      input  I_updatePredTaken, I_updatePredTarget,
      output O_mispredict, O_redirectPC
   );

endinterface

// File: rtl/ceespu_sat_counter.sv
// ---------------------------------------------------------------------------
// ceespu_sat_counter
// Next-state logic of a 2-bit saturating counter.
//   ctr_i   : current counter
//   taken_i : resolved outcome (1 = count up, 0 = count down)
//   ctr_o   : next counter, saturating at CTR_SNT / CTR_ST
// ---------------------------------------------------------------------------
module ceespu_sat_counter
   import ceespu_pkg::*;
(
   input  ctr_e ctr_i,
   input  logic taken_i,
   output ctr_e ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      unique case (ctr_i)
         CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
         CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
         CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
         CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
         default: ctr_o = ctr_i;
      endcase
   end

endmodule

// File: rtl/ceespu_branch_predictor.sv
// ---------------------------------------------------------------------------
// ceespu_branch_predictor
// Direct-mapped table of 2-bit saturating counters with target tags, plus a
// registered mispredict/redirect generator for flushing fetch and decode.
//   I_clk  : clock, rising edge
//   I_rst  : synchronous active-high reset
//   bp     : slave side of ceespu_branch_predictor_if
//            (combinational lookup, 1-cycle update, registered redirect)
// The table lives in flops so it can be cleared on reset and read
// combinationally. Lookup and update to the same entry in one cycle see the
// pre-update contents (no bypass).
// ---------------------------------------------------------------------------
module ceespu_branch_predictor
   import ceespu_pkg::*;
#(
   parameter int IDX_BITS = 4
) (
   input  logic I_clk,
   input  logic I_rst,
   ceespu_branch_predictor_if.slave bp
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = 30 - IDX_BITS;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   ctr_e             ctr_q    [ENTRIES];

   logic        mispredict_q, mispredict_d;
   logic [31:0] redirect_q,   redirect_d;

   // Lookup
   logic [IDX_BITS-1:0] p_idx;
   logic [TAG_W-1:0]    p_tag;
   logic                p_hit;

   // PC bits [1:0] are always zero for word-aligned fetch
   logic [1:0] unused_pc_lsb;
   assign unused_pc_lsb = bp.I_predictPC[1:0];

   assign p_idx = bp.I_predictPC[IDX_BITS+1:2];
   assign p_tag = bp.I_predictPC[31:IDX_BITS+2];
   assign p_hit = valid_q[p_idx] && (tag_q[p_idx] == p_tag);

   assign bp.O_predictTaken  = p_hit && ctr_q[p_idx][1];
   assign bp.O_predictTarget = p_hit ? target_q[p_idx] : 32'd0;

   // Update
   logic [IDX_BITS-1:0] u_idx;
   logic [TAG_W-1:0]    u_tag;
   logic                u_hit;
   logic                wr_en;
   ctr_e                sat_next;
   ctr_e                entry_ctr_d;
   logic [31:0]         entry_target_d;

   assign u_idx = bp.I_updatePC[IDX_BITS+1:2];
   assign u_tag = bp.I_updatePC[31:IDX_BITS+2];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   ceespu_sat_counter u_sat (
      .ctr_i   (ctr_q[u_idx]),
      .taken_i (bp.I_updateTaken),
      .ctr_o   (sat_next)
   );

   // A not-taken miss leaves the table alone; everything else writes the
   // entry. On a hit, valid and tag are rewritten with their current values.
   always_comb begin
      wr_en          = bp.I_updateValid && (u_hit || bp.I_updateTaken);
      entry_ctr_d    = u_hit ? sat_next : CTR_WT;
      entry_target_d = bp.I_updateTaken ? bp.I_updateTarget : target_q[u_idx];
   end

   // Mispredict / redirect
   always_comb begin
      mispredict_d = bp.I_updateValid &&
                     ((bp.I_updatePredTaken != bp.I_updateTaken) ||
                      (bp.I_updateTaken &&
                       (bp.I_updatePredTarget != bp.I_updateTarget)));
      redirect_d   = bp.I_updateTaken ? bp.I_updateTarget
                                      : bp.I_updatePC + INSTR_BYTES;
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
         mispredict_q <= 1'b0;
         redirect_q   <= 32'd0;
      end else begin
         if (wr_en) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= entry_target_d;
            ctr_q[u_idx]    <= entry_ctr_d;
         end
         mispredict_q <= mispredict_d;
         redirect_q   <= redirect_d;
      end
   end

   assign bp.O_mispredict = mispredict_q;
   assign bp.O_redirectPC = redirect_q;

endmodule

// File: doc/ceespu_branch_predictor.md
# ceespu_branch_predictor

Branch predictor and redirect generator for the ceespu pipeline, on the opposite side of the branch decision from the compare unit. Fetch queries it with the current PC and gets a taken/not-taken guess plus a target. Execute reports the resolved outcome: the compare unit's doBranch result, the real target and the guess that fetch used. The block trains a direct-mapped table of 2-bit saturating counters with target tags, and issues a registered mispredict/redirect to flush fetch.

## Interface
- IDX_BITS, default 4: table index width; the table holds 2^IDX_BITS entries.
- I_clk  in  1  sole clock, rising edge.
- I_rst  in  1  reset, synchronous and active-high.
- I_predictPC  in  32  fetch PC, byte address, word aligned.
- O_predictTaken  out  1  predicted taken; combinational from table state.
- O_predictTarget  out  32  predicted target; combinational; 0 when there is no hit.
- I_updateValid  in  1  a resolved conditional or unconditional branch is presented this cycle.
- I_updatePC  in  32  PC of the resolved branch.
- I_updateTaken  in  1  resolved outcome, the compare unit's doBranch.
- I_updateTarget  in  32  resolved branch target.
- I_updatePredTaken  in  1  the O_predictTaken value fetch used for this branch.
- I_updatePredTarget  in  32  the O_predictTarget value fetch used for this branch.
- O_mispredict  out  1  registered one-cycle pulse that flushes fetch and decode.
- O_redirectPC  out  32  registered correct next PC; meaningful only while O_mispredict=1.

## Operation
**Indexing**
- idx = PC[IDX_BITS+1:2].
- tag = PC[31:IDX_BITS+2].

**Entry contents:** valid (1 bit), tag, target (32 bits), ctr (2 bits).
- ctr encodings: SNT=00, WNT=01, WT=10, ST=11.

**Lookup**
- hit = valid[idx] && tag matches.
- O_predictTaken = hit && ctr[1].
- O_predictTarget = hit ? target : 0.

**Update** (edge with I_updateValid=1, applied to the entry at the update idx)
- Hit, taken: ctr increments, saturating at 11; target is overwritten with I_updateTarget.
- Hit, not taken: ctr decrements, saturating at 00; target is unchanged.
- Miss, taken: allocate the entry. Set valid=1, write the tag and target, set ctr=WT (10). This evicts any previous occupant.
- Miss, not taken: no change.

**Mispredict** (registered, evaluated with I_updateValid=1)
- Condition: (I_updatePredTaken != I_updateTaken) || (I_updateTaken && I_updatePredTarget != I_updateTarget).
- O_redirectPC = I_updateTaken ? I_updateTarget : I_updatePC + 4, with 32-bit wrap.
- When I_updateValid=0, O_mispredict=0 on the next edge.

**Reset**
- All valid bits are cleared, all ctr values are set to WNT, and stored tags and targets are cleared to 0.
- O_mispredict=0 and O_redirectPC=0.
- O_predictTaken=0 and O_predictTarget=0 immediately after reset, because nothing hits.

## Timing
- Prediction has zero latency: it is combinational from table registers.
- Update latency is 1 cycle: the table reflects an update from the edge on which I_updateValid was sampled.
- Simultaneous lookup and update to the same idx: lookup returns the pre-update contents. There is no bypass.
- O_mispredict and O_redirectPC are valid the cycle after the update is sampled. O_mispredict lasts exactly 1 cycle per update.
- Back-to-back updates are supported every cycle with no stalls. Two consecutive mispredicts produce two consecutive pulses.
- Reset takes priority over an update on the same edge. A pending mispredict is dropped: O_mispredict=0 after the reset edge.

## Structure
- Shared package ceespu_pkg holds:
  - the counter encodings (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST);
  - the instruction-size constant INSTR_BYTES=4, used for the fall-through PC.
- Sub-module ceespu_sat_counter: 2-bit saturating next-state logic with inputs ctr and taken, and output next ctr. It is instantiated once, on the update path.
- The table is implemented in flops, not block RAM, because it needs a synchronous reset clear and combinational reads.

## Test plan
- Reset, then query PC=0x100 → O_predictTaken=0, O_predictTarget=0.
- Update PC=0x100, taken, target=0x200, predTaken=0 → next cycle O_mispredict=1 and O_redirectPC=0x200; a following query of 0x100 gives taken with target 0x200 (ctr=WT).
- Two more taken updates on 0x100, then three not-taken updates → the prediction stays taken after the first not-taken (ST→WT) and flips after the second (WT→WNT); a not-taken update with predTaken=1 gives O_redirectPC=0x104.
- Aliasing: train 0x100 (IDX_BITS=4), then a taken update at 0x500 → 0x100 now misses, and 0x500 hits with ctr=WT.
- Same-cycle query and update to 0x100 → the query shows the old value and the new value appears the next cycle; a correct prediction with the same target gives O_mispredict=0.
- Assert I_rst in the cycle after a mispredicting update → O_mispredict=0 and every query misses.
